// File: rtl/pipelined_cache_control.sv
// Control FSM for the two-way pipelined cache. It sequences dirty-line writeback,
// line fill and re-read of the set, and keeps saturating hit/miss counters.
module pipelined_cache_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_read,
  input  logic             req_write,
  input  logic             hit,
  input  logic             dirty_signal,
  input  logic             pmem_resp,
  output logic             mem_resp,
  output logic             stall,
  output logic             pmem_read,
  output logic             pmem_write,
  output logic             data_read,
  output logic             dirty_read,
  output logic             LRU_read,
  output logic             tag_read,
  output logic             valid_read,
  output logic [1:0]       data_load,
  output logic             dirty_load,
  output logic             LRU_load,
  output logic             tag_load,
  output logic             valid_load,
  output logic             addr_out_sel,
  output logic             data_in_sel,
  output logic             dirty_in,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_COMPARE   = 2'd0,
    S_WRITEBACK = 2'd1,
    S_FILL      = 2'd2,
    S_REREAD    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_hit_count;
  logic [CNT_W-1:0] r_miss_count;
  logic             w_req;
  logic             w_hit_evt;
  logic             w_miss_evt;

  assign w_req      = req_read | req_write;
  assign w_hit_evt  = rst_n && (r_state == S_COMPARE) && w_req && hit;
  assign w_miss_evt = rst_n && (r_state == S_COMPARE) && w_req && !hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_COMPARE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_COMPARE:   if (w_miss_evt) w_next = dirty_signal ? S_WRITEBACK : S_FILL;
      S_WRITEBACK: if (pmem_resp) w_next = S_FILL;
      S_FILL:      if (pmem_resp) w_next = S_REREAD;
      S_REREAD:    w_next = S_COMPARE;
    endcase
  end

  // Outputs are gated by rst_n so nothing is loaded or requested while reset is held.
  always_comb begin
    mem_resp     = 1'b0;
    stall        = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    data_read    = 1'b1;
    dirty_read   = 1'b1;
    LRU_read     = 1'b1;
    tag_read     = 1'b1;
    valid_read   = 1'b1;
    data_load    = 2'b00;
    dirty_load   = 1'b0;
    LRU_load     = 1'b0;
    tag_load     = 1'b0;
    valid_load   = 1'b0;
    addr_out_sel = 1'b0;
    data_in_sel  = 1'b0;
    dirty_in     = 1'b0;
    if (rst_n) begin
      unique case (r_state)
        S_COMPARE: begin
          if (w_req && hit) begin
            mem_resp = 1'b1;
            LRU_load = 1'b1;
            if (req_write) begin
              data_load  = 2'b01;
              dirty_load = 1'b1;
              dirty_in   = 1'b1;
            end
          end else if (w_req) begin
            stall = 1'b1;
          end
        end
        S_WRITEBACK: begin
          stall        = 1'b1;
          pmem_write   = 1'b1;
          addr_out_sel = 1'b1;
          {data_read, dirty_read, LRU_read, tag_read, valid_read} = 5'b00000;
        end
        S_FILL: begin
          stall     = 1'b1;
          pmem_read = 1'b1;
          {data_read, dirty_read, LRU_read, tag_read, valid_read} = 5'b00000;
          if (pmem_resp) begin
            data_load   = 2'b10;
            data_in_sel = 1'b1;
            tag_load    = 1'b1;
            valid_load  = 1'b1;
            dirty_load  = 1'b1;
          end
        end
        S_REREAD: stall = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_hit_evt && r_hit_count != CNT_MAX)   r_hit_count  <= r_hit_count + CNT_ONE;
      if (w_miss_evt && r_miss_count != CNT_MAX) r_miss_count <= r_miss_count + CNT_ONE;
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
  assign dbg_state  = r_state;

endmodule
